// File: rtl/cache_wr_buffer.sv
// Line-granular write-back buffer between the cache line bus and main_mem.
// Optional feature: define WB_COALESCE_EN to merge writes to an already-buffered line.
module cache_wr_buffer #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int DEPTH         = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_LEN-1:0]                 up_addr,
    input  logic                                up_rd_req,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    up_rd_line,
    input  logic                                up_wr_req,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    up_wr_line,
    output logic                                up_gnt,
    output logic [ADDR_LEN-1:0]                 mem_addr,
    output logic                                mem_rd_req,
    input  logic [32*(2**LINE_ADDR_LEN)-1:0]    mem_rd_line,
    output logic                                mem_wr_req,
    output logic [32*(2**LINE_ADDR_LEN)-1:0]    mem_wr_line,
    input  logic                                mem_gnt,
    output logic                                wb_empty
);

    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int LINE_W    = 32 * LINE_SIZE;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_RD_MEM,
        S_RD_RSP
    } state_t;

    state_t               r_state;
    logic [ADDR_LEN-1:0]  r_ent_addr [DEPTH];
    logic [LINE_W-1:0]    r_ent_line [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic                 r_gnt;
    logic                 r_mem_rd_req;
    logic                 r_mem_wr_req;
    logic                 r_empty;
    logic [LINE_W-1:0]    r_rd_line;
    logic [LINE_W-1:0]    r_mem_wr_line;
    logic [ADDR_LEN-1:0]  r_mem_addr;

    logic                 w_hit;
    logic [PTR_W-1:0]     w_hit_idx;
    logic                 w_up_free;
    logic                 w_full;
    logic                 w_wr_go;
    logic                 w_merge;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_rd_go;
    logic                 w_rd_hit;
    logic                 w_rd_miss;
    logic [CNT_W-1:0]     w_count_nxt;

    // Scan oldest to youngest so the last match found is the youngest entry.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            logic [PTR_W-1:0] v_idx;
            v_idx = r_head + PTR_W'(k);
            if (r_valid[v_idx] && (r_ent_addr[v_idx] == up_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = v_idx;
            end
        end
    end

    // Upstream requests are only looked at while no grant is outstanding and
    // the FSM is not busy servicing a miss.
    assign w_up_free = !r_gnt && ((r_state == S_IDLE) || (r_state == S_DRAIN));
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop     = (r_state == S_DRAIN) && mem_gnt;
    assign w_wr_go   = w_up_free && up_wr_req;

`ifdef WB_COALESCE_EN
    logic w_head_busy;
    // The head line is already latched onto the memory bus during a drain,
    // so a rewrite of it must become a fresh entry.
    assign w_head_busy = (r_state == S_DRAIN) && (w_hit_idx == r_head);
    assign w_merge     = w_wr_go && w_hit && !w_head_busy;
`else
    assign w_merge     = 1'b0;
`endif

    assign w_push    = w_wr_go && !w_merge && !w_full;
    assign w_rd_go   = w_up_free && up_rd_req && !up_wr_req;
    assign w_rd_hit  = w_rd_go && w_hit;
    assign w_rd_miss = w_rd_go && !w_hit;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Entry storage carries no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ent_addr[r_tail] <= up_addr;
            r_ent_line[r_tail] <= up_wr_line;
        end
`ifdef WB_COALESCE_EN
        if (w_merge) begin
            r_ent_line[w_hit_idx] <= up_wr_line;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_valid       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_gnt         <= 1'b0;
            r_mem_rd_req  <= 1'b0;
            r_mem_wr_req  <= 1'b0;
            r_empty       <= 1'b1;
            r_rd_line     <= '0;
            r_mem_wr_line <= '0;
            r_mem_addr    <= '0;
        end else begin
            r_gnt <= w_push || w_merge || w_rd_hit;
            if (w_rd_hit) begin
                r_rd_line <= r_ent_line[w_hit_idx];
            end
            if (w_push) begin
                r_tail          <= r_tail + PTR_W'(1);
                r_valid[r_tail] <= 1'b1;
            end
            if (w_pop) begin
                r_head          <= r_head + PTR_W'(1);
                r_valid[r_head] <= 1'b0;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);

            case (r_state)
                S_IDLE: begin
                    if (w_rd_miss) begin
                        r_state      <= S_RD_MEM;
                        r_mem_rd_req <= 1'b1;
                        r_mem_addr   <= up_addr;
                    end else if (r_count != '0) begin
                        r_state       <= S_DRAIN;
                        r_mem_wr_req  <= 1'b1;
                        r_mem_addr    <= r_ent_addr[r_head];
                        r_mem_wr_line <= r_ent_line[r_head];
                    end
                end
                S_DRAIN: begin
                    if (mem_gnt) begin
                        r_state      <= S_IDLE;
                        r_mem_wr_req <= 1'b0;
                    end
                end
                S_RD_MEM: begin
                    if (mem_gnt) begin
                        r_state      <= S_RD_RSP;
                        r_mem_rd_req <= 1'b0;
                        r_rd_line    <= mem_rd_line;
                        r_gnt        <= 1'b1;
                    end
                end
                S_RD_RSP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign up_gnt      = r_gnt;
    assign up_rd_line  = r_rd_line;
    assign mem_addr    = r_mem_addr;
    assign mem_rd_req  = r_mem_rd_req;
    assign mem_wr_req  = r_mem_wr_req;
    assign mem_wr_line = r_mem_wr_line;
    assign wb_empty    = r_empty;

endmodule

// File: tb/tb_cache_wr_buffer.sv
// Directed bench for cache_wr_buffer: expected drains are queued when writes are
// issued and checked as main_mem sees them; refill data is checked at up_gnt.
module tb_cache_wr_buffer;

    localparam int LINE_ADDR_LEN = 3;
    localparam int ADDR_LEN      = 9;
    localparam int DEPTH         = 4;
    localparam int LW            = 32 * (1 << LINE_ADDR_LEN);

    logic                clk = 1'b0;
    logic                rst;
    logic [ADDR_LEN-1:0] up_addr;
    logic                up_rd_req;
    logic [LW-1:0]       up_rd_line;
    logic                up_wr_req;
    logic [LW-1:0]       up_wr_line;
    logic                up_gnt;
    logic [ADDR_LEN-1:0] mem_addr;
    logic                mem_rd_req;
    logic [LW-1:0]       mem_rd_line;
    logic                mem_wr_req;
    logic [LW-1:0]       mem_wr_line;
    logic                mem_gnt;
    logic                wb_empty;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        logic [ADDR_LEN-1:0] addr;
        logic [LW-1:0]       line;
    } ent_t;
    ent_t q_wr[$];

    cache_wr_buffer #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN),
        .ADDR_LEN(ADDR_LEN),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .up_addr(up_addr),
        .up_rd_req(up_rd_req),
        .up_rd_line(up_rd_line),
        .up_wr_req(up_wr_req),
        .up_wr_line(up_wr_line),
        .up_gnt(up_gnt),
        .mem_addr(mem_addr),
        .mem_rd_req(mem_rd_req),
        .mem_rd_line(mem_rd_line),
        .mem_wr_req(mem_wr_req),
        .mem_wr_line(mem_wr_line),
        .mem_gnt(mem_gnt),
        .wb_empty(wb_empty)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required end of test");
        $fatal(1, "watchdog");
    end

    function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < (1 << LINE_ADDR_LEN); i++) begin
            l[32*i +: 32] = base + 32'(i);
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_write(input logic [ADDR_LEN-1:0] a, input logic [LW-1:0] l);
        bit merged;
        ent_t e;
        merged = 1'b0;
`ifdef WB_COALESCE_EN
        // Index 0 is the line being drained, so only younger entries merge.
        for (int i = q_wr.size() - 1; i >= 1; i--) begin
            if (!merged && q_wr[i].addr == a) begin
                q_wr[i].line = l;
                merged = 1'b1;
            end
        end
`endif
        if (!merged) begin
            e.addr = a;
            e.line = l;
            q_wr.push_back(e);
        end
    endtask

    task automatic wait_gnt(input int max, output int lat);
        lat = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge clk);
            if (up_gnt === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic up_write(input string tag, input logic [ADDR_LEN-1:0] a, input logic [LW-1:0] l);
        int lat;
        up_addr    = a;
        up_wr_line = l;
        up_wr_req  = 1'b1;
        model_write(a, l);
        wait_gnt(20, lat);
        chk({tag, "_lat"}, lat, 1);
        up_wr_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic up_read_hit(input string tag, input logic [ADDR_LEN-1:0] a, input logic [LW-1:0] exp);
        int lat;
        up_addr   = a;
        up_rd_req = 1'b1;
        wait_gnt(20, lat);
        chk({tag, "_lat"}, lat, 1);
        chk({tag, "_data"}, up_rd_line, exp);
        chk({tag, "_no_memrd"}, mem_rd_req, 1'b0);
        up_rd_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic serve_write(input string tag);
        int   lat;
        ent_t e;
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (mem_wr_req === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_req"}, (lat >= 0), 1'b1);
        if (lat < 0) return;
        chk({tag, "_expected"}, (q_wr.size() != 0), 1'b1);
        if (q_wr.size() == 0) return;
        e = q_wr.pop_front();
        chk({tag, "_addr"}, mem_addr, e.addr);
        chk({tag, "_line"}, mem_wr_line, e.line);
        chk({tag, "_no_rd"}, mem_rd_req, 1'b0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk({tag, "_empty"}, wb_empty, (q_wr.size() == 0));
    endtask

    initial begin
        int lat;
        rst         = 1'b0;
        up_addr     = 9'h012;
        up_rd_req   = 1'b0;
        up_wr_req   = 1'b1;
        up_wr_line  = mk_line(32'hA0);
        mem_rd_line = '0;
        mem_gnt     = 1'b0;

        // Reset held with a write pending
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", up_gnt, 1'b0);
            chk("rst_empty", wb_empty, 1'b1);
            chk("rst_memreq", {mem_rd_req, mem_wr_req}, 2'b00);
        end
        chk("rst_rdline", up_rd_line, '0);
        chk("rst_memaddr", mem_addr, '0);
        chk("rst_memline", mem_wr_line, '0);

        // Release: pending write to 0x012 is accepted one cycle later
        rst = 1'b1;
        model_write(9'h012, mk_line(32'hA0));
        wait_gnt(20, lat);
        chk("w012_lat", lat, 1);
        chk("w012_not_empty", wb_empty, 1'b0);
        chk("w012_no_mem_yet", {mem_rd_req, mem_wr_req}, 2'b00);
        up_wr_req = 1'b0;
        @(negedge clk);
        chk("w012_gnt_pulse", up_gnt, 1'b0);
        serve_write("drain012");

        // Fill to capacity with the drain stalled
        for (int k = 1; k <= DEPTH; k++) begin
            up_write("fill", 9'(k), mk_line(32'h100 * k));
        end
        up_addr    = 9'h005;
        up_wr_line = mk_line(32'h500);
        up_wr_req  = 1'b1;
        model_write(9'h005, mk_line(32'h500));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("full_no_gnt", up_gnt, 1'b0);
        end
        serve_write("drain001");
        wait_gnt(3, lat);
        chk("w005_after_pop", lat, 1);
        up_wr_req = 1'b0;
        @(negedge clk);
        for (int k = 2; k <= 5; k++) begin
            serve_write("drain_fill");
        end

        // Read hit on a buffered line
        up_write("w033", 9'h033, mk_line(32'hB0));
        chk("w033_draining", mem_wr_req, 1'b1);
        up_read_hit("rd033", 9'h033, mk_line(32'hB0));
        serve_write("drain033");

        // Read miss waits behind an active drain
        up_write("w001", 9'h001, mk_line(32'hE0));
        up_addr   = 9'h044;
        up_rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("miss_waits", {mem_rd_req, up_gnt}, 2'b00);
        end
        serve_write("drain001b");
        lat = -1;
        for (int i = 0; i < 20; i++) begin
            if (mem_rd_req === 1'b1) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
        chk("miss_rdreq", (lat >= 0), 1'b1);
        chk("miss_addr", mem_addr, 9'h044);
        chk("miss_no_wr", mem_wr_req, 1'b0);
        mem_rd_line = mk_line(32'hF0);
        mem_gnt     = 1'b1;
        @(negedge clk);
        mem_gnt     = 1'b0;
        chk("miss_gnt", up_gnt, 1'b1);
        chk("miss_data", up_rd_line, mk_line(32'hF0));
        chk("miss_rdreq_drop", mem_rd_req, 1'b0);
        up_rd_req = 1'b0;
        @(negedge clk);
        chk("miss_gnt_pulse", {up_gnt, mem_rd_req, mem_wr_req}, 3'b000);

        // Duplicate address writes; the youngest data must be forwarded
        up_write("w006", 9'h006, mk_line(32'h600));
        up_write("w007c", 9'h007, mk_line(32'hC0));
        up_write("w007d", 9'h007, mk_line(32'hD0));
        up_read_hit("rd007", 9'h007, mk_line(32'hD0));
        while (q_wr.size() != 0) begin
            serve_write("drain_dup");
        end
        @(negedge clk);
        chk("final_idle", {mem_rd_req, mem_wr_req}, 2'b00);
        chk("final_empty", wb_empty, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_wr_buffer.md
Name: cache_wr_buffer

Overview:
- Line-granular write-back buffer inserted between the cache's memory bus and main_mem.
- Absorbs dirty-line evictions in one cycle so the cache does not wait on memory write latency.
- Forwards buffered lines to cache refill reads and drains entries to main_mem in the background.
- Both sides use the line bus protocol: addr, rd_req, rd_line, wr_req, wr_line, gnt.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (LINE_SIZE = 1<<LINE_ADDR_LEN).
- ADDR_LEN, 9, line-address width (tag+set).
- DEPTH, 4, number of buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- up_addr  in  ADDR_LEN  cache-side line address.
- up_rd_req  in  1  cache refill read request; held until up_gnt.
- up_rd_line  out  32 x LINE_SIZE  refill data; valid in the up_gnt cycle.
- up_wr_req  in  1  cache eviction write request; held until up_gnt.
- up_wr_line  in  32 x LINE_SIZE  eviction data.
- up_gnt  out  1  one-cycle registered grant to the cache.
- mem_addr  out  ADDR_LEN  main_mem line address.
- mem_rd_req  out  1  main_mem read request.
- mem_rd_line  in  32 x LINE_SIZE  main_mem read data; valid when mem_gnt=1.
- mem_wr_req  out  1  main_mem write request.
- mem_wr_line  out  32 x LINE_SIZE  main_mem write data.
- mem_gnt  in  1  main_mem grant.
- wb_empty  out  1  high when no entries are buffered.

Behaviour:
- Reset (rst=0, async) clears:
  - up_gnt, mem_rd_req, mem_wr_req, count, head and tail pointers, all entry valid bits, FSM state (to IDLE).
  - up_rd_line, mem_addr and mem_wr_line to 0.
  - wb_empty=1.
- Reset mid-operation abandons any in-flight memory transaction; buffered lines are lost.
- Storage is a circular FIFO of {addr, line}: count in 0..DEPTH, pointers wrap modulo DEPTH.
- A request is only considered while up_gnt=0, so a held request is never serviced twice.
- Upstream write:
  - Condition: up_wr_req & !up_gnt & count<DEPTH.
  - Next edge pushes {up_addr, up_wr_line} at the tail and sets up_gnt=1 for one cycle. Latency 1 cycle.
  - When full, no grant; the request waits until a drain pop frees space.
- Upstream read hit (any valid entry whose addr equals up_addr):
  - Next edge loads up_rd_line from the youngest matching entry and pulses up_gnt. Latency 1 cycle.
  - The memory bus is not touched.
- Upstream read miss: serviced by the FSM via main_mem.
- FSM states: IDLE, DRAIN, RD_MEM, RD_RSP.
- IDLE:
  - Pending read miss -> RD_MEM. Reads have priority over drain.
  - Else count>0 -> DRAIN.
  - Else stay IDLE.
- DRAIN:
  - mem_wr_req=1, mem_addr/mem_wr_line = head entry.
  - On mem_gnt: pop the head, go to IDLE.
  - A read miss arriving during DRAIN waits for the drain to finish.
- RD_MEM:
  - mem_rd_req=1, mem_addr=up_addr.
  - On mem_gnt: capture mem_rd_line into up_rd_line, go to RD_RSP.
- RD_RSP: up_gnt=1 for this single cycle, then IDLE.
- Read bypass around older buffered writes is safe: a miss means no buffered entry has that address.
- Simultaneous push and pop in one edge is legal: count is unchanged, both pointers advance.
- A push is permitted while DRAIN is active. The head entry stays stable until it is popped.
- mem_rd_req and mem_wr_req are never high together. Both outputs are registered from the FSM.
- wb_empty = (count==0), registered.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - An upstream write whose up_addr matches a valid entry overwrites that entry's line in place: no push, count unchanged, 1-cycle grant, accepted even when full.
  - Exception: if the match is the head entry and DRAIN is active, the write is pushed as a new entry, or stalls if full.
- Undefined:
  - Every write pushes a new entry; duplicate addresses are allowed.
  - Read forwarding uses the youngest match.

Test Plan:
- Reset with wr_req pending, then release: up_gnt=0, wb_empty=1, no mem request until the first write is accepted.
- Write addr 0x012 with line words 0..7 = 0xA0..0xA7: up_gnt one cycle later. Then drain: mem_wr_req with mem_addr=0x012 and matching data; wb_empty=1 after mem_gnt.
- Hold mem_gnt=0 and issue 5 writes (addrs 0x001..0x005): first 4 are granted; the 5th is granted only after the first drain pop (mem_addr=0x001).
- Buffer 0x033 = 0xB0..0xB7, then read 0x033: up_rd_line = 0xB0..0xB7 one cycle later; mem_rd_req stays 0.
- Read miss 0x044 during an active drain of 0x001: mem_rd_req only after the write's mem_gnt; up_gnt the cycle after the read's mem_gnt, carrying main_mem data.
- WB_COALESCE_EN: write 0x007 twice (data C, then D) with drain blocked: count=1, read 0x007 returns D. Without the macro: count=2, read still returns D.
